// File: rtl/sadd_word.sv
// Bit-serial word adder/subtractor: LSB-first operand bits, one beat per valid cycle.
// Ports: clk, rst (async high), start/sub, in_valid/a_i/b_i in; s_o/s_valid, busy, done, result, cout, ovf out.
module sadd_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             in_valid,
  input  logic             a_i,
  input  logic             b_i,
  output logic             s_o,
  output logic             s_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         next;
  logic           mode;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           b_eff;
  logic           c_nxt;
  logic           last;
  logic           run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next    = state;
    run     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    s_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) next = RUN;
      end
      RUN: begin
        run     = 1'b1;
        busy    = 1'b1;
        s_valid = in_valid;
        if (in_valid && last) next = DONE;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted and the carry preloaded with 1.
  assign b_eff = b_i ^ mode;
  assign s_o   = run & (a_i ^ b_eff ^ carry);
  assign c_nxt = (a_i & b_eff) | (a_i & carry) | (b_eff & carry);
  assign last  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode   <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mode  <= sub;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (in_valid) begin
            carry  <= c_nxt;
            result <= {s_o, result[WIDTH-1:1]};
            if (last) begin
              cout <= c_nxt;
              // Signed overflow: carry into the sign bit differs from carry out.
              ovf  <= carry ^ c_nxt;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sadd_word.md
SADD_WORD -- requirements
Module: sadd_word

Interface
REQ-001 Parameter: WIDTH, default 8, word length in bits; SHALL be >= 2.
REQ-002 Port: clk  in  1  rising-edge clock; sole clock of the block.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: start  in  1  begin a new word operation; sampled only in IDLE.
REQ-005 Port: sub  in  1  mode, sampled with start: 0 = A+B, 1 = A-B.
REQ-006 Port: in_valid  in  1  a_i/b_i carry a valid bit this cycle; 0 = stall.
REQ-007 Port: a_i  in  1  operand A bit, LSB first.
REQ-008 Port: b_i  in  1  operand B bit, LSB first.
REQ-009 Port: s_o  out  1  sum/difference bit for the current beat (combinational).
REQ-010 Port: s_valid  out  1  s_o is valid this cycle.
REQ-011 Port: busy  out  1  high in RUN and DONE.
REQ-012 Port: done  out  1  one-cycle pulse when a word completes.
REQ-013 Port: result  out  WIDTH  assembled word result, registered.
REQ-014 Port: cout  out  1  final carry; in sub mode 1 = no borrow (A >= B unsigned).
REQ-015 Port: ovf  out  1  signed two's-complement overflow of the last word.

Function
REQ-016 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-017 IDLE with start=1: latch sub into mode register, load carry <= sub, clear beat counter, go to RUN next cycle.
REQ-018 In IDLE, a_i, b_i and in_valid SHALL be ignored; s_valid=0.
REQ-019 In RUN, b_eff = b_i XOR mode; s_o = a_i XOR b_eff XOR carry; s_valid = in_valid.
REQ-020 In RUN with in_valid=1: carry <= majority(a_i, b_eff, carry); result shifts right one place with s_o entering the MSB; counter increments.
REQ-021 In RUN with in_valid=0: carry, result and counter SHALL hold (stall of any length).
REQ-022 On the valid beat where counter == WIDTH-1: cout <= carry-out of that beat; ovf <= carry-in XOR carry-out of that beat; next state DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1; result, cout and ovf are final; next state IDLE.
REQ-024 start in RUN or DONE SHALL be ignored; no restart and no error flag.
REQ-025 result, cout and ovf SHALL hold their values from completion until the next word's first valid beat (result) or completion (cout, ovf).
REQ-026 Latency: done SHALL be high the cycle after the WIDTH-th valid beat; with no stalls, WIDTH+1 cycles after the start cycle.
REQ-027 The beat counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap within a word.

Reset
REQ-028 While rst=1, the block SHALL force state=IDLE, carry=0, mode=0, counter=0, result=0, cout=0, ovf=0, done=0, busy=0, s_valid=0.
REQ-029 rst asserted mid-word SHALL abort the operation immediately; the partial result is discarded and no done pulse is produced.

Verification
REQ-030 WIDTH=8, sub=0, A=0x5A, B=0x3C, no stalls -> result=0x96, cout=0, ovf=1, done 9 cycles after start.
REQ-031 WIDTH=8, sub=0, A=0xFF, B=0x01 -> result=0x00, cout=1, ovf=0.
REQ-032 WIDTH=8, sub=1, A=0x10, B=0x20 -> result=0xF0, cout=0, ovf=0; second word sub=1, A=0x80, B=0x01 -> result=0x7F, cout=1, ovf=1.
REQ-033 Case of REQ-030 with in_valid low for 3 cycles after beat 2 and 1 cycle after beat 6 -> identical result/flags, done 4 cycles later, s_valid low during stalls.
REQ-034 start pulsed during RUN and during DONE -> ignored, current word unaffected; rst pulsed after beat 4 -> all outputs 0, no done, next start operates normally.
